instr_fetch: RTL and testbench

//  Fetch stage; upstream producer for instr_decode. Drives i_instruction/i_pc/i_pcplus4, consumes its o_branch_valid/o_branch_addr.

---
 rtl/multicore_pkg.sv | 10 +
 rtl/fetch_buffer.sv | 53 +++++
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// multicore_pkg: shared core constants and the fetch buffer entry type
package multicore_pkg;
  localparam int INST_SIZE = 32;
  localparam logic [6:0] NOOP_CODE = 7'b0010011;
  localparam logic [INST_SIZE-1:0] FETCH_RESET_PC = '0;
  typedef struct packed {
    logic [INST_SIZE-1:0] instr;
    logic [INST_SIZE-1:0] pc;
  } t_fetch_entry;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched {instr, pc} entries with clear
module fetch_buffer
  import multicore_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  t_fetch_entry din,
  output t_fetch_entry dout,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);
  t_fetch_entry mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  // clear wins over push/pop; pointers wrap naturally for power-of-2 depth
  always_comb begin
    do_push = push && !clear;
    do_pop = pop && !clear && !empty;
    rd_d = clear ? '0 : rd_q + PW'(do_pop);
    wr_d = clear ? '0 : wr_q + PW'(do_push);
    cnt_d = clear ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // entry storage, no reset needed since occupancy guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !clear && !pop && full));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: pipelined fetch stage with credit-limited requests and redirects (misalign trap via FETCH_MISALIGN_TRAP_EN)
module instr_fetch
  import multicore_pkg::*;
#(
  parameter logic [INST_SIZE-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  input  logic                 i_en,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_pcplus4,
  output logic                 o_empty,
  input  logic                 i_branch_valid,
  input  logic [INST_SIZE-1:0] i_branch_addr,
  input  logic                 i_redirect_valid,
  input  logic [INST_SIZE-1:0] i_redirect_addr,
  output logic                 o_imem_req,
  output logic [INST_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic                 o_misalign,
  output logic [INST_SIZE-1:0] o_misalign_addr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [INST_SIZE-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, raw_tgt, tgt;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
  logic redir, halted, gnt_ok, drop, push, pop, full;
  t_fetch_entry head, wr_entry;
  assign redir = i_redirect_valid || i_branch_valid;
  assign raw_tgt = i_redirect_valid ? i_redirect_addr : i_branch_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d, bad;
  logic [INST_SIZE-1:0] mis_addr_q, mis_addr_d;
  assign tgt = raw_tgt;
  assign bad = redir && (tgt[1:0] != 2'b00);
  assign halted = mis_q;
  assign o_misalign = mis_q;
  assign o_misalign_addr = mis_addr_q;
  // misaligned redirect sets the trap, an aligned one clears it
  always_comb begin
    mis_d = redir ? bad : mis_q;
    mis_addr_d = bad ? tgt : mis_addr_q;
  end
  // trap state
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      mis_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end
`else
  assign tgt = raw_tgt & ~INST_SIZE'(3);
  assign halted = 1'b0;
  assign o_misalign = 1'b0;
  assign o_misalign_addr = '0;
`endif
  assign o_imem_req = !i_reset && !halted && !full && (out_q + count) < CW'(FIFO_DEPTH);
  assign o_imem_addr = fetch_pc_q;
  assign wr_entry = '{instr: i_imem_rdata, pc: resp_pc_q};
  assign o_instruction = o_empty ? {{(INST_SIZE-7){1'b0}}, NOOP_CODE} : head.instr;
  assign o_pc = o_empty ? resp_pc_q : head.pc;
  assign o_pcplus4 = o_pc + INST_SIZE'(4);
  // credit, discard and PC bookkeeping; a redirect drops this cycle's response and discards all in flight
  always_comb begin
    gnt_ok = o_imem_req && i_imem_gnt;
    drop = i_imem_rvalid && (disc_q != '0);
    push = i_imem_rvalid && !drop && !redir;
    pop = i_en && !o_empty && !redir;
    out_d = out_q + CW'(gnt_ok) - CW'(i_imem_rvalid);
    disc_d = redir ? out_d : disc_q - CW'(drop);
    fetch_pc_d = redir ? tgt : fetch_pc_q + (gnt_ok ? INST_SIZE'(4) : '0);
    resp_pc_d = redir ? tgt : resp_pc_q + (push ? INST_SIZE'(4) : '0);
  end
  // fetch state
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
  fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk(i_aclk),
    .rst(i_reset),
    .clear(redir),
    .push(push),
    .pop(pop),
    .din(wr_entry),
    .dout(head),
    .count(count),
    .empty(o_empty),
    .full(full)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a 1-cycle in-order imem
module tb_instr_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0, bv = 1'b0, rv = 1'b0, gnt = 1'b0, rvalid = 1'b0, rsp_en = 1'b1;
  logic [31:0] ba = '0, ra = '0, rdata = '0;
  logic [31:0] instr, pc, pc4, iaddr, maddr;
  logic empty, req, mis;
  logic [31:0] q [$];
  int checks = 0, errors = 0;
  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .i_aclk(clk), .i_reset(rst), .i_en(en),
    .o_instruction(instr), .o_pc(pc), .o_pcplus4(pc4), .o_empty(empty),
    .i_branch_valid(bv), .i_branch_addr(ba),
    .i_redirect_valid(rv), .i_redirect_addr(ra),
    .o_imem_req(req), .o_imem_addr(iaddr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_misalign(mis), .o_misalign_addr(maddr)
  );
  // imem: a grant seen this cycle is answered next cycle, in order; reset drops everything
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      rvalid = 1'b0;
      rdata = '0;
    end else begin
      if (rvalid) void'(q.pop_front());
      rvalid = rsp_en && q.size() > 0;
      rdata = '0;
      if (rvalid) rdata = q[0] ^ 32'hA500_0000;
      if (req && gnt) q.push_back(iaddr);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; gnt = 1'b0; bv = 1'b0; rv = 1'b0; rsp_en = 1'b1; ba = '0; ra = '0;
    nxt();
    nxt();
  endtask
  initial begin
    do_reset();
    mid();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_instr", instr, 32'h13);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_req", 32'(req), 32'd0);
    check("rst_mis", 32'(mis), 32'd0);
    check("rst_maddr", maddr, 32'h0);
    nxt(); rst = 1'b0; gnt = 1'b1; en = 1'b1;
    mid(); check("t1_req", 32'(req), 32'd1); check("t1_addr0", iaddr, 32'h0);
    nxt(); mid(); check("t1_addr1", iaddr, 32'h4); check("t1_empty1", 32'(empty), 32'd1);
    nxt(); mid(); check("t1_pc0", pc, 32'h0); check("t1_ins0", instr, 32'hA500_0000);
    nxt(); mid(); check("t1_pc4", pc, 32'h4); check("t1_ins4", instr, 32'hA500_0004);
    nxt(); mid(); check("t1_pc8", pc, 32'h8); check("t1_pcp4", pc4, 32'hC);
    nxt(); en = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      mid();
      check("t2_hold", pc, 32'hC);
      if (k == 6) check("t2_req6", 32'(req), 32'd1);
      if (k >= 7) check("t2_credit", 32'(req), 32'd0);
      nxt();
    end
    en = 1'b1;
    for (int k = 10; k <= 14; k++) begin
      mid();
      check("t2_resume", pc, 32'hC + 32'(4 * (k - 10)));
      nxt();
    end
    do_reset(); rst = 1'b0; gnt = 1'b1; en = 1'b1; rsp_en = 1'b0;
    nxt();
    nxt(); bv = 1'b1; ba = 32'h100; gnt = 1'b0;
    nxt(); bv = 1'b0; gnt = 1'b1; rsp_en = 1'b1;
    mid();
    check("t3_addr", iaddr, 32'h100); check("t3_req", 32'(req), 32'd1);
    check("t3_empty", 32'(empty), 32'd1); check("t3_pc", pc, 32'h100);
    nxt(); mid(); check("t3_drop1", 32'(empty), 32'd1); check("t3_pc_e", pc, 32'h100);
    nxt(); mid(); check("t3_drop2", 32'(empty), 32'd1);
    nxt(); mid(); check("t3_head", pc, 32'h100); check("t3_ins", instr, 32'hA500_0100);
    do_reset(); rst = 1'b0; gnt = 1'b1; en = 1'b0;
    nxt(); rv = 1'b1; ra = 32'h200; bv = 1'b1; ba = 32'h300;
    nxt(); rv = 1'b0; bv = 1'b0;
    mid(); check("t4_addr", iaddr, 32'h200); check("t4_empty", 32'(empty), 32'd1); check("t4_pc", pc, 32'h200);
    nxt(); mid(); check("t4_drop", 32'(empty), 32'd1);
    nxt(); mid(); check("t4_head", pc, 32'h200); check("t4_ins", instr, 32'hA500_0200);
    do_reset(); rst = 1'b0; gnt = 1'b1; en = 1'b0; rv = 1'b1; ra = 32'h102;
    nxt(); rv = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mid();
    check("t5_mis", 32'(mis), 32'd1); check("t5_maddr", maddr, 32'h102);
    check("t5_req", 32'(req), 32'd0); check("t5_nop", instr, 32'h13);
    nxt(); mid(); check("t5_halt", 32'(req), 32'd0); check("t5_empty", 32'(empty), 32'd1);
    nxt(); bv = 1'b1; ba = 32'h400;
    mid(); check("t5_halt2", 32'(req), 32'd0);
    nxt(); bv = 1'b0;
    mid(); check("t5_clr", 32'(mis), 32'd0); check("t5_req2", 32'(req), 32'd1); check("t5_addr2", iaddr, 32'h400);
`else
    mid();
    check("t5_mis", 32'(mis), 32'd0); check("t5_maddr", maddr, 32'h0);
    check("t5_req", 32'(req), 32'd1); check("t5_addr", iaddr, 32'h100); check("t5_pc", pc, 32'h100);
    nxt(); mid(); check("t5_empty", 32'(empty), 32'd1);
    nxt(); mid(); check("t5_head", pc, 32'h100); check("t5_ins", instr, 32'hA500_0100);
`endif
    do_reset(); rst = 1'b0; gnt = 1'b1; en = 1'b1;
    repeat (3) nxt();
    nxt(); gnt = 1'b0;
    mid(); check("t6_pre", pc, 32'h8);
    nxt(); rst = 1'b1;
    mid(); check("t6_req_rst", 32'(req), 32'd0);
    nxt(); rst = 1'b0;
    mid();
    check("t6_empty", 32'(empty), 32'd1); check("t6_instr", instr, 32'h13);
    check("t6_pc", pc, 32'h0); check("t6_pc4", pc4, 32'h4); check("t6_mis", 32'(mis), 32'd0);
    check("t6_req", 32'(req), 32'd1); check("t6_addr", iaddr, 32'h0);
    nxt(); gnt = 1'b1;
    nxt();
    nxt(); mid(); check("t6_head", pc, 32'h0); check("t6_ins", instr, 32'hA500_0000);
    do_reset(); rst = 1'b0; rv = 1'b1; ra = 32'hFFFF_FFFC;
    nxt(); rv = 1'b0; gnt = 1'b1;
    mid(); check("t7_addr", iaddr, 32'hFFFF_FFFC); check("t7_pc", pc, 32'hFFFF_FFFC); check("t7_pc4", pc4, 32'h0);
    nxt(); mid(); check("t7_wrap", iaddr, 32'h0);
    nxt(); mid(); check("t7_head", pc, 32'hFFFF_FFFC); check("t7_ins", instr, 32'h5AFF_FFFC); check("t7_hpc4", pc4, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
